// File: rtl/ibus_map_pkg.sv
// Shared io-bus address map: transmit FIFO window, its STATUS/CTRL
// registers, and the DMA engine registers, so every io decoder agrees.
package ibus_map_pkg;

    // Transmit FIFO data window (word addresses)
    localparam logic [13:0] TXF_WIN_BASE   = 14'h3E00;
    localparam logic [13:0] TXF_WIN_LIMIT  = 14'h3E3F;

    // Transmit FIFO registers
    localparam logic [13:0] TXF_STATUS_ADR = 14'h3E40;
    localparam logic [13:0] TXF_CTRL_ADR   = 14'h3E41;

    // STATUS bit positions
    localparam int TXF_ST_EMPTY     = 0;
    localparam int TXF_ST_FULL      = 1;
    localparam int TXF_ST_OVF       = 2;
    localparam int TXF_ST_COUNT_LSB = 8;

    // CTRL bit positions
    localparam int TXF_CTRL_FLUSH   = 0;
    localparam int TXF_CTRL_CLR_OVF = 1;

    // DMA engine registers
    localparam logic [13:0] DMA_SRC_ADR  = 14'h3FF0;
    localparam logic [13:0] DMA_DST_ADR  = 14'h3FF1;
    localparam logic [13:0] DMA_LEN_ADR  = 14'h3FF2;
    localparam logic [13:0] DMA_CTRL_ADR = 14'h3FF3;

    // Which transmit FIFO resource a read address selects
    typedef enum logic [1:0] {
        TXF_SEL_NONE,
        TXF_SEL_DATA,
        TXF_SEL_STATUS,
        TXF_SEL_CTRL
    } txf_sel_e;

    function automatic logic txf_in_window(input logic [13:0] adr);
        return (adr >= TXF_WIN_BASE) && (adr <= TXF_WIN_LIMIT);
    endfunction

    function automatic txf_sel_e txf_decode(input logic [13:0] adr);
        if (txf_in_window(adr))     return TXF_SEL_DATA;
        if (adr == TXF_STATUS_ADR)  return TXF_SEL_STATUS;
        if (adr == TXF_CTRL_ADR)    return TXF_SEL_CTRL;
        return TXF_SEL_NONE;
    endfunction

endpackage

// File: rtl/sync_fifo_core.sv
// Synchronous FIFO core: storage, wrapping pointers, occupancy count.
// A push into a full FIFO is taken only when a pop frees the slot in the
// same cycle; otherwise it is reported on drop_o.
module sync_fifo_core #(
    parameter int DEPTH = 16,
    parameter int W     = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [W-1:0]  head_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          drop_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop_w;
    logic          push_ok_w;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign valid_o   = ~empty_o;
    assign count_o   = count_q;
    assign head_o    = mem_q[rptr_q];

    assign pop_w     = valid_o & ready_i;
    assign push_ok_w = push_i & (~full_o | pop_w);
    assign drop_o    = push_i & full_o & ~pop_w;

    // Next pointer/count: flush empties, otherwise advance per push/pop
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok_w) wptr_d = wptr_q + AW'(1);
            if (pop_w)     rptr_d = rptr_q + AW'(1);
            case ({push_ok_w, pop_w})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage write port
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; count gates validity, so its contents never matter until written.
        if (push_ok_w) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/ibus_tx_fifo.sv
// Memory-mapped transmit FIFO on the 16-bit io bus. Window writes push,
// the stream side pops on tx_valid & tx_ready, and reads of head/STATUS
// return through a fixed two-stage pipe into the chained read-data path.
module ibus_tx_fifo
    import ibus_map_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CW    = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rst_pipe,
    input  logic        ibus_wen,
    input  logic [15:2] ibus_wadr,
    input  logic [15:0] ibus32_wdata,
    input  logic        ibus_ren,
    input  logic [15:2] ibus_radr,
    input  logic [15:0] ibus32_rdata_in,
    output logic [15:0] ibus32_rdata,
    output logic        tx_valid,
    output logic [15:0] tx_data,
    input  logic        tx_ready
);

    logic          push_w;
    logic          ctrl_wr_w;
    logic          flush_w;
    logic          ovf_clr_w;
    logic [CW-1:0] count_w;
    logic          full_w;
    logic          empty_w;
    logic          drop_w;
    logic          ovf_q, ovf_d;
    logic [15:0]   status_w;
    txf_sel_e      rsel_w;
    logic          rd_hit1_q, rd_hit1_d;
    logic [15:0]   rd_val1_q, rd_val1_d;
    logic          rd_hit2_q;
    logic [15:0]   rd_val2_q;

    assign push_w    = ibus_wen & txf_in_window(ibus_wadr);
    assign ctrl_wr_w = ibus_wen & (ibus_wadr == TXF_CTRL_ADR);
    assign flush_w   = rst_pipe | (ctrl_wr_w & ibus32_wdata[TXF_CTRL_FLUSH]);
    assign ovf_clr_w = rst_pipe | (ctrl_wr_w & ibus32_wdata[TXF_CTRL_CLR_OVF]);

    sync_fifo_core #(
        .DEPTH (DEPTH),
        .W     (16),
        .CW    (CW)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush_w),
        .push_i  (push_w),
        .wdata_i (ibus32_wdata),
        .ready_i (tx_ready),
        .valid_o (tx_valid),
        .head_o  (tx_data),
        .count_o (count_w),
        .full_o  (full_w),
        .empty_o (empty_w),
        .drop_o  (drop_w)
    );

    // Sticky overflow: a clear beats a same-cycle drop
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr_w)   ovf_d = 1'b0;
        else if (drop_w) ovf_d = 1'b1;
    end

    // STATUS word assembled from current FIFO state
    always_comb begin
        status_w                            = '0;
        status_w[TXF_ST_COUNT_LSB +: CW]    = count_w;
        status_w[TXF_ST_OVF]                = ovf_q;
        status_w[TXF_ST_FULL]               = full_w;
        status_w[TXF_ST_EMPTY]              = empty_w;
    end

    // Read stage-1 select: value sampled before any same-cycle push/pop
    always_comb begin
        rsel_w    = ibus_ren ? txf_decode(ibus_radr) : TXF_SEL_NONE;
        rd_hit1_d = (rsel_w != TXF_SEL_NONE);
        rd_val1_d = '0;
        case (rsel_w)
            TXF_SEL_DATA:   rd_val1_d = empty_w ? 16'h0000 : tx_data;
            TXF_SEL_STATUS: rd_val1_d = status_w;
            default:        rd_val1_d = '0;
        endcase
    end

    // Overflow flag and the two read-pipe stages
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q     <= 1'b0;
            rd_hit1_q <= 1'b0;
            rd_val1_q <= '0;
            rd_hit2_q <= 1'b0;
            rd_val2_q <= '0;
        end else begin
            ovf_q     <= ovf_d;
            rd_hit1_q <= rd_hit1_d;
            rd_val1_q <= rd_val1_d;
            rd_hit2_q <= rd_hit1_q;
            rd_val2_q <= rd_val1_q;
        end
    end

    assign ibus32_rdata = rd_hit2_q ? rd_val2_q : ibus32_rdata_in;

endmodule

// File: tb/tb_ibus_tx_fifo.sv
// Self-checking bench for ibus_tx_fifo: directed scenarios plus a random
// phase, checked by a queue-based reference model and a scoreboard monitor.
module tb_ibus_tx_fifo;

    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst_pipe;
    logic        ibus_wen;
    logic [15:2] ibus_wadr;
    logic [15:0] ibus32_wdata;
    logic        ibus_ren;
    logic [15:2] ibus_radr;
    logic [15:0] ibus32_rdata_in;
    logic [15:0] ibus32_rdata;
    logic        tx_valid;
    logic [15:0] tx_data;
    logic        tx_ready;

    always #5 clk = ~clk;

    ibus_tx_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rst_pipe        (rst_pipe),
        .ibus_wen        (ibus_wen),
        .ibus_wadr       (ibus_wadr),
        .ibus32_wdata    (ibus32_wdata),
        .ibus_ren        (ibus_ren),
        .ibus_radr       (ibus_radr),
        .ibus32_rdata_in (ibus32_rdata_in),
        .ibus32_rdata    (ibus32_rdata),
        .tx_valid        (tx_valid),
        .tx_data         (tx_data),
        .tx_ready        (tx_ready)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a queue of words plus a sticky overflow bit.
    // ------------------------------------------------------------------
    typedef struct {
        int          due;
        bit          hit;
        logic [15:0] val;
    } rd_exp_t;

    logic [15:0] mq[$];
    bit          movf = 1'b0;
    rd_exp_t     rd_exp[$];

    function automatic bit in_win(input logic [13:0] a);
        return (a >= 14'h3E00) && (a <= 14'h3E3F);
    endfunction

    function automatic logic [15:0] model_status();
        logic [15:0] s;
        s = 16'(mq.size()) * 16'd256;
        if (movf)               s = s + 16'd4;
        if (mq.size() == DEPTH) s = s + 16'd2;
        if (mq.size() == 0)     s = s + 16'd1;
        return s;
    endfunction

    always @(posedge clk) begin : model
        int      k;
        bit      pop, push, drop, ctrl, flush, clr;
        rd_exp_t e;
        k   = cyc;
        cyc = cyc + 1;
        if (!rst_n) begin
            mq.delete();
            rd_exp.delete();
            movf = 1'b0;
        end else begin
            if (ibus_ren) begin
                e.due = k + 2;
                e.hit = 1'b1;
                e.val = 16'h0000;
                if (in_win(ibus_radr))          e.val = (mq.size() > 0) ? mq[0] : 16'h0000;
                else if (ibus_radr == 14'h3E40) e.val = model_status();
                else if (ibus_radr == 14'h3E41) e.val = 16'h0000;
                else                            e.hit = 1'b0;
                rd_exp.push_back(e);
            end
            pop   = (mq.size() > 0) && tx_ready;
            push  = ibus_wen && in_win(ibus_wadr);
            drop  = push && (mq.size() == DEPTH) && !pop;
            ctrl  = ibus_wen && (ibus_wadr == 14'h3E41);
            flush = rst_pipe || (ctrl && ibus32_wdata[0]);
            clr   = rst_pipe || (ctrl && ibus32_wdata[1]);
            if (pop) void'(mq.pop_front());
            if (push && !drop) mq.push_back(ibus32_wdata);
            if (flush) mq.delete();
            if (clr)       movf = 1'b0;
            else if (drop) movf = 1'b1;
        end
    end

    // Scoreboard monitor: compares read data and stream outputs mid-cycle
    always @(negedge clk) begin : monitor
        logic [15:0] exp_rd;
        rd_exp_t     e;
        if (mon_en) begin
            exp_rd = ibus32_rdata_in;
            if (rd_exp.size() > 0 && rd_exp[0].due == cyc) begin
                e = rd_exp.pop_front();
                if (e.hit) exp_rd = e.val;
            end
            check("mon_rdata", ibus32_rdata, exp_rd);
            check("mon_tx_valid", 16'(tx_valid), 16'(mq.size() > 0));
            if (mq.size() > 0) check("mon_tx_data", tx_data, mq[0]);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ibus_wen = 1'b0;
        ibus_ren = 1'b0;
        rst_pipe = 1'b0;
    endtask

    task automatic wr(input logic [13:0] adr, input logic [15:0] data);
        ibus_wen     = 1'b1;
        ibus_wadr    = adr;
        ibus32_wdata = data;
        tick();
        ibus_wen     = 1'b0;
    endtask

    task automatic rd_expect(input logic [13:0] adr, input logic [15:0] exp, input string name);
        ibus_ren  = 1'b1;
        ibus_radr = adr;
        tick();
        ibus_ren  = 1'b0;
        tick();
        @(negedge clk);
        check(name, ibus32_rdata, exp);
        tick();
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int r;
        int ready_pct;
        rst_n           = 1'b0;
        idle();
        tx_ready        = 1'b0;
        ibus_wadr       = '0;
        ibus_radr       = '0;
        ibus32_wdata    = '0;
        ibus32_rdata_in = 16'hA5A5;

        // Reset and idle reads
        tick();
        mon_en = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        rd_expect(14'h3E40, 16'h0001, "status_after_reset");
        check("tx_valid_after_reset", 16'(tx_valid), 16'h0000);
        rd_expect(14'h1000, 16'hA5A5, "unmapped_passthrough");
        rd_expect(14'h3E41, 16'h0000, "ctrl_reads_zero");

        // Fill to full, then overflow
        for (int i = 0; i < 16; i++) wr(14'h3E00 + 14'(i), 16'h0100 + 16'(i));
        rd_expect(14'h3E40, 16'h1002, "status_full");
        rd_expect(14'h3E05, 16'h0100, "head_peek");
        wr(14'h3E10, 16'hDEAD);
        rd_expect(14'h3E40, 16'h1006, "status_overflow");
        wr(14'h3E41, 16'h0002);
        rd_expect(14'h3E40, 16'h1002, "status_ovf_cleared");

        // Push while full on the first pop cycle
        tx_ready     = 1'b1;
        ibus_wen     = 1'b1;
        ibus_wadr    = 14'h3E20;
        ibus32_wdata = 16'hBEEF;
        @(negedge clk);
        check("first_pop_head", tx_data, 16'h0100);
        tick();
        ibus_wen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("drain_valid", 16'(tx_valid), 16'h0001);
            check("drain_data", tx_data, (i < 15) ? 16'h0101 + 16'(i) : 16'hBEEF);
            tick();
        end
        tx_ready = 1'b0;
        check("drained_tx_valid", 16'(tx_valid), 16'h0000);
        rd_expect(14'h3E40, 16'h0001, "status_drained");

        // Flush + clear with a concurrent pop
        for (int i = 0; i < 5; i++) wr(14'h3E00 + 14'(i), 16'h2000 + 16'(i));
        ibus_wen     = 1'b1;
        ibus_wadr    = 14'h3E41;
        ibus32_wdata = 16'h0003;
        tx_ready     = 1'b1;
        tick();
        ibus_wen = 1'b0;
        tx_ready = 1'b0;
        check("flush_tx_valid", 16'(tx_valid), 16'h0000);
        rd_expect(14'h3E40, 16'h0001, "status_after_flush");

        // DMA-style head reads around a pop
        wr(14'h3E00, 16'h1234);
        wr(14'h3E01, 16'h5678);
        ibus_ren  = 1'b1;
        ibus_radr = 14'h3E00;
        tx_ready  = 1'b1;
        tick();
        tx_ready  = 1'b0;
        tick();
        ibus_ren  = 1'b0;
        @(negedge clk);
        check("dma_read_t2", ibus32_rdata, 16'h1234);
        tick();
        @(negedge clk);
        check("dma_read_t3", ibus32_rdata, 16'h5678);
        tick();
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;

        // Randomized traffic with alternating drain pressure
        for (int c = 0; c < 3000; c++) begin
            ready_pct       = ((c / 200) % 2 == 1) ? 85 : 15;
            tx_ready        = ($urandom_range(99) < ready_pct);
            ibus32_rdata_in = 16'($urandom);
            ibus32_wdata    = 16'($urandom);
            ibus_wen        = ($urandom_range(99) < 70);
            r = $urandom_range(99);
            if (r < 80)      ibus_wadr = 14'h3E00 + 14'($urandom_range(63));
            else if (r < 83) ibus_wadr = 14'h3E41;
            else if (r < 86) ibus_wadr = 14'h3E40;
            else if (r < 90) ibus_wadr = 14'h3FF0 + 14'($urandom_range(3));
            else             ibus_wadr = 14'($urandom);
            ibus_ren = ($urandom_range(99) < 50);
            r = $urandom_range(99);
            if (r < 50)      ibus_radr = 14'h3E00 + 14'($urandom_range(63));
            else if (r < 75) ibus_radr = 14'h3E40;
            else if (r < 80) ibus_radr = 14'h3E41;
            else             ibus_radr = 14'($urandom);
            rst_pipe = ($urandom_range(999) < 5);
            tick();
        end
        idle();
        tx_ready        = 1'b0;
        ibus32_rdata_in = 16'h5A5A;
        tick();
        tick();

        // Reset in the middle of a write/read burst
        wr(14'h3E41, 16'h0003);
        for (int i = 0; i < 6; i++) begin
            ibus_ren  = 1'b1;
            ibus_radr = 14'h3E40;
            wr(14'h3E00 + 14'(i), 16'h7000 + 16'(i));
        end
        ibus_wen     = 1'b1;
        ibus_wadr    = 14'h3E06;
        ibus32_wdata = 16'h7006;
        rst_n        = 1'b0;
        tick();
        check("reset_tx_valid", 16'(tx_valid), 16'h0000);
        check("reset_rdata_passthrough", ibus32_rdata, ibus32_rdata_in);
        idle();
        rst_n = 1'b1;
        rd_expect(14'h3E40, 16'h0001, "status_after_midreset");
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
